// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus arbiter.
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic        OWNER_CPU = 1'b0;
  localparam logic        OWNER_DMA = 1'b1;
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // Counter must hold values up to TIMEOUT; keep at least one bit when disabled.
  function automatic int cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dbus_rr_pick.sv
// Two-way grant picker: a lone requester wins; ties go by round-robin or CPU priority.
module dbus_rr_pick
  import dbus_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic last_grant_i,
  input  logic rr_i,
  output logic grant_o
);

  always_comb begin
    grant_o = OWNER_CPU;
    if (cpu_req_i && dma_req_i) grant_o = rr_i ? ~last_grant_i : OWNER_CPU;
    else if (dma_req_i)         grant_o = OWNER_DMA;
  end

endmodule

// File: rtl/dbus_arbiter.sv
// CPU/DMA arbiter for the single data-memory port: serialises transactions,
// stalls the pipeline on CPU accesses and aborts hung bus cycles.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int RR      = 1,
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_byteen_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_stall_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  input  logic [3:0]  dma_byteen_i,
  output logic [31:0] dma_rdata_o,
  output logic        dma_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_byteen_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_o,
  output logic        owner_o
);

  localparam int              CW      = cnt_w(TIMEOUT);
  localparam logic [CW-1:0]   TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic          owner_q, owner_d, last_q, last_d;
  logic          we_q, we_d, err_q, err_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]    be_q, be_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant, resp;

  dbus_rr_pick u_pick (
    .cpu_req_i    (cpu_req_i),
    .dma_req_i    (dma_req_i),
    .last_grant_i (last_q),
    .rr_i         (1'(RR != 0)),
    .grant_o      (grant)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (cpu_req_i || dma_req_i) begin
        state_d = BUSY;
        owner_d = grant;
        last_d  = grant;
        cnt_d   = '0;
        err_d   = 1'b0;
        if (grant == OWNER_DMA) begin
          we_d = dma_we_i; addr_d = dma_addr_i; wdata_d = dma_wdata_i; be_d = dma_byteen_i;
        end else begin
          we_d = cpu_we_i; addr_d = cpu_addr_i; wdata_d = cpu_wdata_i; be_d = cpu_byteen_i;
        end
      end
      // An ack in the same cycle the counter expires still counts as success.
      BUSY: if (mem_ack_i) begin
        rdata_d = we_q ? 32'h0 : mem_rdata_i;
        err_d   = 1'b0;
        state_d = RESP;
      end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
        rdata_d = ERR_RDATA;
        err_d   = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= OWNER_CPU;
      last_q  <= OWNER_DMA;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp         = (state_q == RESP);
  assign cpu_ack_o    = resp && (owner_q == OWNER_CPU);
  assign dma_ack_o    = resp && (owner_q == OWNER_DMA);
  assign cpu_rdata_o  = cpu_ack_o ? rdata_q : '0;
  assign dma_rdata_o  = dma_ack_o ? rdata_q : '0;
  assign err_o        = resp && err_q;
  assign cpu_stall_o  = cpu_req_i && !cpu_ack_o;
  assign mem_req_o    = (state_q == BUSY);
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_byteen_o = be_q;
  assign owner_o      = owner_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios plus a randomized run against a
// transaction-level model. A second instance runs with CPU-fixed priority.
module tb_dbus_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, dma_req, dma_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [3:0]  cpu_be, dma_be;

  logic [31:0] r_cpu_rdata, r_dma_rdata, r_mem_addr, r_mem_wdata;
  logic        r_cpu_ack, r_cpu_stall, r_dma_ack, r_mem_req, r_mem_we, r_err, r_owner;
  logic [3:0]  r_mem_be;
  logic [31:0] f_cpu_rdata, f_dma_rdata, f_mem_addr, f_mem_wdata;
  logic        f_cpu_ack, f_cpu_stall, f_dma_ack, f_mem_req, f_mem_we, f_err, f_owner;
  logic [3:0]  f_mem_be;

  int checks = 0;
  int errors = 0;

  dbus_arbiter #(.RR(1), .TIMEOUT(TO)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_byteen_i(cpu_be), .cpu_rdata_o(r_cpu_rdata), .cpu_ack_o(r_cpu_ack), .cpu_stall_o(r_cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_byteen_i(dma_be), .dma_rdata_o(r_dma_rdata), .dma_ack_o(r_dma_ack),
    .mem_req_o(r_mem_req), .mem_we_o(r_mem_we), .mem_addr_o(r_mem_addr), .mem_wdata_o(r_mem_wdata),
    .mem_byteen_o(r_mem_be), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .err_o(r_err), .owner_o(r_owner)
  );

  dbus_arbiter #(.RR(0), .TIMEOUT(TO)) u_fx (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_byteen_i(cpu_be), .cpu_rdata_o(f_cpu_rdata), .cpu_ack_o(f_cpu_ack), .cpu_stall_o(f_cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_byteen_i(dma_be), .dma_rdata_o(f_dma_rdata), .dma_ack_o(f_dma_ack),
    .mem_req_o(f_mem_req), .mem_we_o(f_mem_we), .mem_addr_o(f_mem_addr), .mem_wdata_o(f_mem_wdata),
    .mem_byteen_o(f_mem_be), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .err_o(f_err), .owner_o(f_owner)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_be = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0; step(); step(); rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 0; #2;
    checks++;
    if ({r_mem_req, r_cpu_ack, r_dma_ack, r_err, r_owner, r_cpu_stall,
         f_mem_req, f_cpu_ack, f_dma_ack, f_err, f_owner, f_cpu_stall} !== 12'h0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0",
        {r_mem_req, r_cpu_ack, r_dma_ack, r_err, r_owner, f_mem_req, f_cpu_ack, f_dma_ack, f_err, f_owner});
    end
    checks++;
    if ({r_cpu_rdata, r_dma_rdata, f_cpu_rdata, f_dma_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_rdata: got %h %h expected 0", r_cpu_rdata, r_dma_rdata);
    end
    checks++;
    if ({r_mem_we, r_mem_addr, r_mem_wdata, r_mem_be, f_mem_we, f_mem_addr, f_mem_wdata, f_mem_be} !== '0) begin
      errors++; $display("FAIL reset_memfields: got %h/%h expected 0", r_mem_addr, f_mem_addr);
    end
    step(); step(); rst_n = 1; step(); #1;
    checks++;
    if (r_mem_req !== 1'b0 || r_cpu_ack !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: mem_req=%b cpu_ack=%b expected 0 0", r_mem_req, r_cpu_ack);
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0100; cpu_be = 4'hf; #1;
    checks++;
    if (r_cpu_stall !== 1'b1 || r_mem_req !== 1'b0) begin
      errors++; $display("FAIL read_c0: stall=%b mem_req=%b expected 1 0", r_cpu_stall, r_mem_req);
    end
    step(); mem_ack = 1; mem_rdata = 32'h1234_5678; #1;
    checks++;
    if (r_mem_req !== 1'b1 || r_cpu_stall !== 1'b1 || r_cpu_ack !== 1'b0 || r_mem_addr !== 32'h100) begin
      errors++; $display("FAIL read_c1: mem_req=%b stall=%b ack=%b addr=%h expected 1 1 0 100",
                         r_mem_req, r_cpu_stall, r_cpu_ack, r_mem_addr);
    end
    step(); mem_ack = 0; mem_rdata = 32'hffff_ffff; #1;
    checks++;
    if (r_cpu_ack !== 1'b1 || r_cpu_rdata !== 32'h1234_5678 || r_cpu_stall !== 1'b0 ||
        r_err !== 1'b0 || r_dma_ack !== 1'b0 || r_mem_req !== 1'b0) begin
      errors++; $display("FAIL read_c2: ack=%b rdata=%h stall=%b err=%b expected 1 12345678 0 0",
                         r_cpu_ack, r_cpu_rdata, r_cpu_stall, r_err);
    end
    cpu_req = 0;
    step(); #1;
    checks++;
    if (r_cpu_ack !== 1'b0 || r_mem_req !== 1'b0 || r_cpu_stall !== 1'b0 || r_cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL read_c3: ack=%b mem_req=%b rdata=%h expected 0 0 0", r_cpu_ack, r_mem_req, r_cpu_rdata);
    end
  endtask

  task automatic test_tie();
    logic exp_dma;
    do_reset();
    cpu_req = 1; cpu_addr = 32'hC000_0000; cpu_be = 4'hf;
    dma_req = 1; dma_addr = 32'hD000_0000; dma_be = 4'hf;
    mem_ack = 1; mem_rdata = 32'h0BAD_CAFE;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) step();
      #1;
      exp_dma = ((c / 3) % 2) == 1;
      if (c % 3 == 1) begin
        checks++;
        if (r_owner !== exp_dma || r_mem_addr !== (exp_dma ? 32'hD000_0000 : 32'hC000_0000)) begin
          errors++; $display("FAIL tie_grant c%0d: owner=%b addr=%h expected owner %b", c, r_owner, r_mem_addr, exp_dma);
        end
      end
      checks++;
      if (c % 3 == 2) begin
        if (r_cpu_ack !== !exp_dma || r_dma_ack !== exp_dma ||
            (exp_dma ? r_dma_rdata : r_cpu_rdata) !== 32'h0BAD_CAFE) begin
          errors++; $display("FAIL tie_rr_ack c%0d: cpu_ack=%b dma_ack=%b expected %b %b",
                             c, r_cpu_ack, r_dma_ack, !exp_dma, exp_dma);
        end
        checks++;
        if (f_cpu_ack !== 1'b1 || f_dma_ack !== 1'b0 || f_cpu_rdata !== 32'h0BAD_CAFE) begin
          errors++; $display("FAIL tie_fixed_ack c%0d: cpu_ack=%b dma_ack=%b expected 1 0", c, f_cpu_ack, f_dma_ack);
        end
      end else if ({r_cpu_ack, r_dma_ack, f_cpu_ack, f_dma_ack} !== 4'b0) begin
        errors++; $display("FAIL tie_noack c%0d: acks=%b expected 0000", c, {r_cpu_ack, r_dma_ack, f_cpu_ack, f_dma_ack});
      end
    end
    idle_inputs(); step();
  endtask

  task automatic test_dma_write();
    logic [31:0] wd;
    wd = $urandom;
    do_reset();
    dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0040; dma_be = 4'b0011; dma_wdata = wd;
    mem_rdata = 32'hDEAD_BEEF;
    for (int n = 1; n <= 5; n++) begin
      step(); #1;
      checks++;
      if (r_mem_req !== 1'b1 || r_mem_we !== 1'b1 || r_mem_addr !== 32'h40 || r_mem_be !== 4'b0011 ||
          r_mem_wdata !== wd || r_owner !== 1'b1 || r_dma_ack !== 1'b0 || r_cpu_ack !== 1'b0) begin
        errors++; $display("FAIL dma_hold n%0d: req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 40 0011 %h",
                           n, r_mem_req, r_mem_we, r_mem_addr, r_mem_be, r_mem_wdata, wd);
      end
    end
    step(); mem_ack = 1; #1;
    checks++;
    if (r_mem_req !== 1'b1) begin
      errors++; $display("FAIL dma_c6: mem_req=%b expected 1", r_mem_req);
    end
    step(); mem_ack = 0; #1;
    checks++;
    if (r_dma_ack !== 1'b1 || r_dma_rdata !== 32'h0 || r_cpu_ack !== 1'b0 || r_err !== 1'b0) begin
      errors++; $display("FAIL dma_ack: dma_ack=%b rdata=%h cpu_ack=%b err=%b expected 1 0 0 0",
                         r_dma_ack, r_dma_rdata, r_cpu_ack, r_err);
    end
    dma_req = 0; step();
  endtask

  task automatic test_timeout(input bit late_ack);
    int  n;
    bit  got;
    n = 0; got = 0;
    do_reset();
    cpu_req = 1; cpu_addr = 32'h0000_0200; cpu_be = 4'hf;
    mem_rdata = late_ack ? 32'hA5A5_5A5A : 32'hFFFF_FFFF;
    for (int c = 0; c < 40; c++) begin
      step(); #1;
      if (r_cpu_ack) begin got = 1; break; end
      if (r_mem_req) begin
        n++;
        if (late_ack && n == TO) mem_ack = 1;
      end
    end
    mem_ack = 0;
    checks++;
    if (!got || n != TO) begin
      errors++; $display("FAIL timeout_len late=%0d: acked=%0d mem_req cycles=%0d expected 1 %0d", late_ack, got, n, TO);
    end
    checks++;
    if (r_err !== !late_ack || r_cpu_rdata !== (late_ack ? 32'hA5A5_5A5A : 32'h0)) begin
      errors++; $display("FAIL timeout_resp late=%0d: err=%b rdata=%h expected %b", late_ack, r_err, r_cpu_rdata, !late_ack);
    end
    cpu_req = 0; step();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    cpu_req = 1; cpu_addr = 32'h0000_0300; cpu_be = 4'hf; mem_rdata = 32'h7777_0001;
    step(); step(); #1;
    checks++;
    if (r_mem_req !== 1'b1) begin
      errors++; $display("FAIL midrst_busy: mem_req=%b expected 1", r_mem_req);
    end
    rst_n = 0; #1;
    checks++;
    if (r_mem_req !== 1'b0 || r_cpu_ack !== 1'b0 || r_dma_ack !== 1'b0 || r_err !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: mem_req=%b acks=%b%b expected 0 00", r_mem_req, r_cpu_ack, r_dma_ack);
    end
    step(); rst_n = 1; #1;
    checks++;
    if (r_mem_req !== 1'b0 || r_cpu_ack !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: mem_req=%b ack=%b expected 0 0", r_mem_req, r_cpu_ack);
    end
    step(); mem_ack = 1; #1;
    checks++;
    if (r_mem_req !== 1'b1 || r_owner !== 1'b0 || r_mem_addr !== 32'h300) begin
      errors++; $display("FAIL midrst_regrant: mem_req=%b owner=%b addr=%h expected 1 0 300", r_mem_req, r_owner, r_mem_addr);
    end
    step(); mem_ack = 0; #1;
    checks++;
    if (r_cpu_ack !== 1'b1 || r_cpu_rdata !== 32'h7777_0001) begin
      errors++; $display("FAIL midrst_ack: ack=%b rdata=%h expected 1 77770001", r_cpu_ack, r_cpu_rdata);
    end
    cpu_req = 0; step();
  endtask

  // Requesters and memory are randomized; the model tracks only which master
  // owns the bus, which ack is due, and the data/error it must carry.
  task automatic test_random();
    logic [31:0] a[2], wd[2], resp_data;
    logic [3:0]  be[2];
    logic        w[2], pend[2], prev_req[2], acked[2];
    logic        inflight, resp_due, resp_now, resp_err, win, last, want_grant, idle_now;
    int          n, dly, r;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      a[m] = 0; wd[m] = 0; be[m] = 0; w[m] = 0; pend[m] = 0; prev_req[m] = 0;
    end
    inflight = 0; resp_due = 0; resp_err = 0; resp_data = 0; win = 0; last = 1; want_grant = 0;
    n = 0; dly = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c != 0) step();
      resp_now = resp_due;
      acked[0] = 0; acked[1] = 0;
      checks++;
      if (resp_due) begin
        if (r_cpu_ack !== (win == 1'b0) || r_dma_ack !== (win == 1'b1) || r_err !== resp_err ||
            (win ? r_dma_rdata : r_cpu_rdata) !== resp_data || (win ? r_cpu_rdata : r_dma_rdata) !== 32'h0) begin
          errors++; $display("FAIL rand_resp c%0d: acks=%b%b err=%b rdata=%h/%h expected owner %b err %b data %h",
                             c, r_cpu_ack, r_dma_ack, r_err, r_cpu_rdata, r_dma_rdata, win, resp_err, resp_data);
        end
        acked[win] = 1; resp_due = 0;
      end else if ({r_cpu_ack, r_dma_ack, r_err} !== 3'b0 || {r_cpu_rdata, r_dma_rdata} !== 64'h0) begin
        errors++; $display("FAIL rand_quiet c%0d: acks=%b%b err=%b expected 0", c, r_cpu_ack, r_dma_ack, r_err);
      end
      checks++;
      if (!inflight) begin
        if (r_mem_req !== want_grant) begin
          errors++; $display("FAIL rand_grant c%0d: mem_req=%b expected %b", c, r_mem_req, want_grant);
        end
        if (want_grant) begin
          win = (prev_req[0] && prev_req[1]) ? ~last : prev_req[1];
          last = win; inflight = 1; n = 0;
          r = $urandom_range(0, 9);
          dly = (r < 7) ? r % 4 : (r == 7) ? TO - 1 : (r == 8) ? TO - 2 : 100;
        end
      end else if (r_mem_req !== 1'b1) begin
        errors++; $display("FAIL rand_busy c%0d: mem_req=%b expected 1", c, r_mem_req);
      end
      idle_now = !inflight && !resp_now;
      mem_ack = 0; mem_rdata = $urandom;
      if (inflight) begin
        checks++;
        if (r_mem_addr !== a[win] || r_mem_we !== w[win] || r_mem_wdata !== wd[win] ||
            r_mem_be !== be[win] || r_owner !== win) begin
          errors++; $display("FAIL rand_fields c%0d: addr=%h we=%b owner=%b expected %h %b %b",
                             c, r_mem_addr, r_mem_we, r_owner, a[win], w[win], win);
        end
        n++;
        if (n == dly + 1) begin
          mem_ack = 1; resp_data = w[win] ? 32'h0 : mem_rdata; resp_err = 0; resp_due = 1; inflight = 0;
        end else if (n == TO) begin
          resp_data = 32'h0; resp_err = 1; resp_due = 1; inflight = 0;
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
      end
      for (int m = 0; m < 2; m++) begin
        if (acked[m]) pend[m] = 0;
        else if (!pend[m]) begin
          if ($urandom_range(0, 2) != 0) begin
            pend[m] = 1; a[m] = $urandom; wd[m] = $urandom;
            w[m] = 1'($urandom_range(0, 1)); be[m] = 4'($urandom_range(0, 15));
          end
          if (m == 0) begin
            cpu_req = pend[0]; cpu_we = w[0]; cpu_addr = a[0]; cpu_wdata = wd[0]; cpu_be = be[0];
          end else begin
            dma_req = pend[1]; dma_we = w[1]; dma_addr = a[1]; dma_wdata = wd[1]; dma_be = be[1];
          end
        end
      end
      prev_req[0] = cpu_req; prev_req[1] = dma_req;
      want_grant = idle_now && (cpu_req || dma_req);
      #1;
      checks++;
      if (r_cpu_stall !== (cpu_req && !(resp_now && win == 1'b0))) begin
        errors++; $display("FAIL rand_stall c%0d: stall=%b req=%b", c, r_cpu_stall, cpu_req);
      end
    end
    idle_inputs(); step(); step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_tie();
    test_dma_write();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter for the single data-memory port of the pipelined MIPS core. The CPU M-stage load/store port and a DMA/debug requester share one downstream memory bus. The block owns the bus, serialises transactions and applies round-robin or CPU-fixed priority. It supplies a stall to the pipeline hazard logic while a CPU access is outstanding, and aborts hung transactions with an error response.

## Interface
Parameters:
- RR, 1: 1 = round-robin on simultaneous requests; 0 = CPU always wins.
- TIMEOUT, 16: cycles in BUSY without mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- cpu_req / cpu_we  in  1 / 1  CPU request; write enable.
- cpu_addr / cpu_wdata  in  32 / 32  CPU address; write data.
- cpu_byteen  in  4  CPU byte enables.
- cpu_rdata  out  32  CPU read data, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  = cpu_req & ~cpu_ack (combinational).
- dma_req, dma_we, dma_addr, dma_wdata, dma_byteen, dma_rdata, dma_ack: same widths and meanings for the DMA master.
- mem_req  out  1  downstream request, held until mem_ack.
- mem_we, mem_addr, mem_wdata, mem_byteen  out  1/32/32/4  driven from the latched transaction.
- mem_rdata  in  32  downstream read data, sampled with mem_ack.
- mem_ack  in  1  downstream completion.
- err  out  1  pulses together with the requester ack on a timeout abort.
- owner  out  1  0 = CPU, 1 = DMA; the master of the current or last transaction.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE, at least one req high:
  - Pick the winner. RR=1 on a tie grants the master not granted last. RR=0 grants the CPU.
  - Latch the winner's we/addr/wdata/byteen, set owner, clear the timeout counter, go to BUSY.
- BUSY:
  - mem_req=1 with the latched fields.
  - On mem_ack: latch mem_rdata, err=0, go to RESP.
  - Otherwise the counter increments. If TIMEOUT≠0 and the counter reaches TIMEOUT, latch rdata=32'h0000_0000, err=1, go to RESP.
- RESP: the owner's ack=1 and the owner's rdata = latched value; err is as latched. Next state is always IDLE.
- Non-owner ack is always 0. Non-owner rdata is 0.
- Requester rules:
  - Hold req and all fields stable until ack.
  - In the cycle after ack, req=1 is a new transaction.
  - The non-granted master keeps waiting. Its request is never dropped or merged.
- mem_ack is ignored in IDLE and RESP. Writes return rdata=0.

## Timing
- Reset values: mem_req=0, all acks=0, err=0, owner=0, rdata outputs 0, state=IDLE. Round-robin last-grant is reset to DMA, so the CPU wins the first tie.
- Minimum latency, with req high in cycle 0 in IDLE:
  - Cycle 1: mem_req=1.
  - mem_ack is legal in cycle 1.
  - Cycle 2: ack pulse.
  - Cycle 3: IDLE, may grant again. This gives 3 cycles per transaction at best.
- General case: mem_ack in cycle k puts the ack in cycle k+1.
- Timeout: mem_req is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT). Ack with err=1 follows in cycle TIMEOUT+1.
- A mem_ack arriving in the same cycle the counter hits TIMEOUT counts as success (err=0).
- Asynchronous reset mid-BUSY drops mem_req immediately. The transaction is lost and no ack is issued.
- cpu_stall rises in the same cycle as cpu_req and falls in the cpu_ack cycle.

## Structure
- Shared package dbus_pkg holds:
  - State enum: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - OWNER_CPU=1'b0, OWNER_DMA=1'b1.
  - ERR_RDATA=32'h0.
  - Timeout counter width $clog2(TIMEOUT+1).
- Sub-module dbus_rr_pick: combinational 2-way picker. Inputs are the two requests, last_grant and RR. Output is the grant index. Keep the last_grant register in the top level.

## Test plan
- Single CPU read, mem_ack in cycle 1 with mem_rdata=32'h1234_5678 -> cpu_ack and cpu_rdata=32'h1234_5678 in cycle 2; cpu_stall high in cycles 0-1 only.
- CPU and DMA both request in cycle 0 with RR=1 after reset -> CPU granted first, DMA granted in the IDLE cycle after cpu_ack. Repeat both -> DMA, then CPU. With RR=0 -> CPU every time.
- DMA write addr=32'h0000_0040, byteen=4'b0011, mem_ack delayed 5 cycles -> mem_* fields stable all 5 cycles; dma_ack one cycle after mem_ack; cpu_ack stays 0.
- TIMEOUT=16, no mem_ack -> mem_req high for 16 cycles, then cpu_ack=1, err=1, cpu_rdata=0. Separately, mem_ack on the 16th BUSY cycle -> err=0.
- reset low for 1 cycle during BUSY -> mem_req and all acks 0 immediately. After release, a held request is re-granted from IDLE.
